// File: rtl/pkg_read_sched.sv
`default_nettype none
// ============================================================================
// Module   : pkg_read_sched
// Function : drains each completed ping-pong package and emits it as a framed
//            byte stream; define PKG_CRC_EN to append a 16-bit sum trailer.
// Revision : 1.0
// ============================================================================
module pkg_read_sched #(
    parameter int         PKG_SIZE  = 60,
    parameter int         CNT_WIDTH = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       rd_clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pkg_ready_async,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic       overrun,
    output logic [7:0] overrun_cnt
);

    localparam logic [15:0]          SIZE16 = 16'(PKG_SIZE);
    localparam logic [CNT_WIDTH-1:0] SIZE_C = CNT_WIDTH'(PKG_SIZE);
    localparam logic [CNT_WIDTH-1:0] ONE_C  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_TRL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 sync0;
    logic                 sync1;
    logic                 sync2;
    logic                 pkg_evt;
    logic                 pending;
    logic                 start;
    logic [1:0]           hdr_idx;
    logic [CNT_WIDTH-1:0] rd_left;
    logic [CNT_WIDTH-1:0] tx_left;
    logic                 inflight;
    logic [7:0]           skid_mem [2];
    logic                 skid_wp;
    logic                 skid_rp;
    logic [1:0]           skid_occ;
    logic [1:0]           occ_proj;
    logic                 skid_has;
    logic                 push;
    logic                 pop;
`ifdef PKG_CRC_EN
    logic [15:0]          csum;
    logic                 trl_idx;
`endif

    assign start    = (state == S_IDLE) && pending && enable;
    assign skid_has = (skid_occ != 2'd0);
    assign push     = fifo_valid && inflight;
    assign pop      = (state == S_PAY) && skid_has && tx_ready;
    // Occupancy the skid will hold next cycle before any newly issued read
    // returns; a read is only safe when that leaves room for its data.
    assign occ_proj = skid_occ + {1'b0, push} - {1'b0, pop};
    assign busy     = (state != S_IDLE);

    assign fifo_rd_en = ((state == S_HDR) && tx_ready && (hdr_idx == 2'd3) && (rd_left != '0))
                     || ((state == S_PAY) && (rd_left != '0) && (occ_proj < 2'd2));

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            pkg_evt <= 1'b0;
        end else begin
            sync0   <= pkg_ready_async;
            sync1   <= sync0;
            sync2   <= sync1;
            pkg_evt <= sync1 & ~sync2;
        end
    end

    // An event coinciding with the start of a frame re-arms pending rather
    // than counting as an overrun.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (start) begin
            pending <= pkg_evt;
        end else if (pkg_evt) begin
            pending <= 1'b1;
            if (pending) begin
                overrun <= 1'b1;
                if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hdr_idx   <= 2'd0;
            rd_left   <= '0;
            tx_left   <= '0;
            inflight  <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (start) begin
                hdr_idx <= 2'd0;
                rd_left <= SIZE_C;
                tx_left <= SIZE_C;
            end else begin
                if ((state == S_HDR) && tx_ready) begin
                    hdr_idx <= hdr_idx + 2'd1;
                end
                if (fifo_rd_en) begin
                    rd_left <= rd_left - ONE_C;
                end
                if (pop) begin
                    tx_left <= tx_left - ONE_C;
                end
            end
            if (fifo_rd_en) begin
                inflight <= 1'b1;
            end else if (fifo_valid) begin
                inflight <= 1'b0;
            end
            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            skid_mem[0] <= 8'd0;
            skid_mem[1] <= 8'd0;
            skid_wp     <= 1'b0;
            skid_rp     <= 1'b0;
            skid_occ    <= 2'd0;
        end else begin
            if (push) begin
                skid_mem[skid_wp] <= fifo_dout;
                skid_wp           <= ~skid_wp;
            end
            if (pop) begin
                skid_rp <= ~skid_rp;
            end
            skid_occ <= occ_proj;
        end
    end

`ifdef PKG_CRC_EN
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            csum    <= 16'd0;
            trl_idx <= 1'b0;
        end else if (start) begin
            csum    <= 16'd0;
            trl_idx <= 1'b0;
        end else begin
            if (pop) begin
                csum <= csum + {8'h00, tx_data};
            end
            if ((state == S_TRL) && tx_ready) begin
                trl_idx <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'd0;
        tx_last   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                case (hdr_idx)
                    2'd0:    tx_data = SYNC_BYTE;
                    2'd1:    tx_data = frame_cnt;
                    2'd2:    tx_data = SIZE16[15:8];
                    default: tx_data = SIZE16[7:0];
                endcase
                if (tx_ready && (hdr_idx == 2'd3)) begin
                    state_nxt = S_PAY;
                end
            end
            S_PAY: begin
                tx_valid = skid_has;
                tx_data  = skid_has ? skid_mem[skid_rp] : 8'd0;
`ifndef PKG_CRC_EN
                tx_last  = skid_has && (tx_left == ONE_C);
`endif
                if (pop && (tx_left == ONE_C)) begin
`ifdef PKG_CRC_EN
                    state_nxt = S_TRL;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef PKG_CRC_EN
            S_TRL: begin
                tx_valid = 1'b1;
                tx_data  = trl_idx ? csum[7:0] : csum[15:8];
                tx_last  = trl_idx;
                if (tx_ready && trl_idx) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/pkg_read_sched.md
# pkg_read_sched

Read-side scheduler for the ping-pong package buffer, running in the `rd_clk` domain. It detects each completed package, drains exactly `PKG_SIZE` bytes from the buffer with 1-cycle-latency reads, and emits a framed byte stream to the SPI/WiFi transmitter. Framing is a 4-byte header, the payload, and an optional checksum. The stream supports `tx_ready` backpressure, and the block detects package overruns.

## Interface
- `PKG_SIZE`, default 60: payload bytes per package, 1..65535.
- `CNT_WIDTH`, default 16: width of the payload byte counter; must satisfy 2^CNT_WIDTH > `PKG_SIZE`.
- `SYNC_BYTE`, default 8'hA5: first header byte.

Ports:
- `rd_clk` in 1: sole clock.
- `rst_n` in 1: reset is synchronous and active-low.
- `enable` in 1: when low, new packages are not started; a frame already in progress completes.
- `pkg_ready_async` in 1: package-complete pulse from the write domain; width ≥ 2 `rd_clk` periods.
- `fifo_rd_en` out 1: read strobe to the buffer.
- `fifo_dout` in 8: buffer read data.
- `fifo_valid` in 1: buffer data valid, exactly 1 cycle after `fifo_rd_en`.
- `tx_data` out 8: stream byte.
- `tx_valid` out 1: stream byte valid.
- `tx_ready` in 1: transmitter accepts the byte.
- `tx_last` out 1: marks the final byte of a frame.
- `busy` out 1: high in any state other than IDLE.
- `frame_cnt` out 8: count of completed frames, wraps.
- `overrun` out 1: sticky overrun flag; cleared only by reset.
- `overrun_cnt` out 8: number of dropped packages, saturates at 255.

## Operation
- **Package detection:** `pkg_ready_async` passes through a 2-flop synchronizer and a rising-edge detector, producing a 1-cycle `pkg_evt`.
- **Pending latch:** `pkg_evt` sets a 1-deep `pending` latch.
- **Overrun:** `pkg_evt` while `pending` is already set sets `overrun` and increments `overrun_cnt` (saturating). The pending package is kept; the new event is dropped.

FSM states: IDLE, HDR, PAY, TRL, DONE.
- **IDLE → HDR:** when `pending` && `enable`. `pending` clears on this transition, and the header index clears to 0.
- **HDR:** emits 4 bytes: `SYNC_BYTE`, `frame_cnt`, `PKG_SIZE[15:8]`, `PKG_SIZE[7:0]`. Each byte advances on `tx_valid` && `tx_ready`. After the 4th byte, go to PAY.
- **PAY reads:**
  - A read is issued when `rd_left` > 0 and `inflight` + `skid_occ` < 2.
  - `rd_left` loads `PKG_SIZE` on entry and decrements per issued read.
  - `inflight` ≤ 1.
- **PAY data path:**
  - Returned bytes enter a 2-entry skid FIFO.
  - The skid FIFO head drives `tx_data`.
  - `fifo_valid` with no read outstanding is discarded.
- **PAY exit:** after the `PKG_SIZE`-th payload byte is accepted, go to TRL if `PKG_CRC_EN` is defined, else to DONE.
- **TRL:** emits the checksum MSB, then LSB (see Configuration).
- **DONE:** lasts 1 cycle. `frame_cnt` increments (255 wraps to 0). Then go to IDLE.
- **`tx_last`:** asserted with the final byte of the frame (payload or trailer).
- **Stream stability:** while `tx_valid` is high and `tx_ready` is low, `tx_data` and `tx_last` hold stable.
- **Reset:** synchronous reset at any point returns the FSM to IDLE and clears the pending latch, skid FIFO, counters and flags. A partial frame is abandoned.

## Timing
- Reset values: `fifo_rd_en`=0, `tx_valid`=0, `tx_data`=0, `tx_last`=0, `busy`=0, `frame_cnt`=0, `overrun`=0, `overrun_cnt`=0.
- Event latency: `pkg_ready_async` rise → `pkg_evt` in 3 cycles.
- Start latency: `pkg_evt` → first `tx_valid` (header byte 0) 2 cycles later when idle and enabled.
- Header entry: `tx_valid` is high in the first HDR cycle.
- Reads: the first `fifo_rd_en` coincides with the cycle the last header byte is accepted. The first payload `tx_valid` follows 2 cycles later.
- Throughput: with `tx_ready` held high, 1 byte per cycle throughout the frame after the first payload byte. No bubbles between header, payload and trailer, except the 1 bubble at the header-to-payload boundary.
- Backpressure:
  - `tx_ready` low stalls read issue within 1 cycle.
  - The skid FIFO never overflows.
  - `fifo_rd_en` is never asserted when `rd_left` = 0.
- Simultaneous events:
  - `pkg_evt` in the DONE cycle sets `pending`.
  - `pkg_evt` in the cycle of IDLE→HDR sets `pending` again; this is not an overrun.

## Configuration
- `PKG_CRC_EN` defined:
  - A 16-bit checksum is accumulated: the sum of payload bytes mod 65536, cleared on HDR entry.
  - It is appended as 2 trailer bytes, MSB first.
  - `tx_last` moves to the checksum LSB.
  - Frame length is `PKG_SIZE` + 6.
- `PKG_CRC_EN` undefined:
  - TRL state and accumulator are absent.
  - Frame length is `PKG_SIZE` + 4.
  - `tx_last` is on the final payload byte.

## Test plan
- **Single package:** reset, `enable`=1, pulse `pkg_ready_async`, `tx_ready`=1, `PKG_SIZE`=60, payload 0..59. Required:
  - Bytes A5,00,00,3C, then 0..59.
  - With `PKG_CRC_EN`: trailer 06,EA.
  - `tx_last` on the last byte; `frame_cnt`=1.
- **Backpressure:** toggle `tx_ready` in a 1-of-3 pattern. Required: the same byte sequence, no duplicates or losses, and `fifo_rd_en` pulse count = 60.
- **Overrun:** three pulses during one frame. Required: second pulse pends and a second frame follows; third pulse gives `overrun`=1 and `overrun_cnt`=1.
- **Enable low:** `enable`=0, pulse. Required: no `tx_valid`. Then `enable`=1: the frame starts 1 cycle later.
- **Mid-frame reset:** `rst_n` low during PAY byte 20. Required: all outputs at reset values next cycle, `fifo_rd_en`=0. A new pulse then yields a clean frame.
- **Wrap:** 256 frames. Required: `frame_cnt` wraps to 0, and header byte 1 reads 00 on frame 257.
